// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: drives the HEX pins from the per-digit segment register.
// Adds a hardware blink at BLINK_HZ and PWM brightness gating on top of the
// active-low segment word, with a fixed two-register path from seg_in to seg_out.
module seg_display_ctrl #(
  parameter int              CLK_HZ        = 50000000,
  parameter int              BLINK_HZ      = 2,
  parameter int              PWM_BITS      = 4,
  parameter int              SEG_W         = 16,
  parameter logic [SEG_W-1:0] BLANK_PATTERN = 16'hFFFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SEG_W-1:0]    seg_in,
  input  logic                blink_en,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [SEG_W-1:0]    seg_out,
  output logic                blink_phase
);

  // Clock cycles spent in each half (SHOW or BLANK) of one blink period.
  localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
  localparam int PRE_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(HALF - 1);
  localparam logic [PWM_BITS-1:0] PWM_FULL = '1;

  if (HALF < 1) begin : g_bad_half
    $error("seg_display_ctrl: CLK_HZ/(2*BLINK_HZ) must be at least 1");
  end

  typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} state_t;

  state_t              state, state_next;
  logic [PRE_W-1:0]    pre, pre_next;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on_p0;
  logic [SEG_W-1:0]    seg_p0;
  logic                visible;
  logic [SEG_W-1:0]    seg_next;

  // Brightness gate: zero is always dark, full scale never drops a cycle.
  function automatic logic pwm_gate(input logic [PWM_BITS-1:0] cnt,
                                    input logic [PWM_BITS-1:0] level);
    if (level == '0)            return 1'b0;
    else if (level == PWM_FULL) return 1'b1;
    else                        return (cnt < level);
  endfunction

  // Blink state register; blink_phase is registered from the same next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SHOW;
      pre         <= '0;
      blink_phase <= 1'b0;
    end else begin
      state       <= state_next;
      pre         <= pre_next;
      blink_phase <= (state_next == BLANK);
    end
  end

  // Blink next state: prescaler held at 0 while disabled so enabling starts a full SHOW.
  always_comb begin
    state_next = state;
    pre_next   = pre;
    if (!blink_en) begin
      state_next = SHOW;
      pre_next   = '0;
    end else if (pre == PRE_LAST) begin
      pre_next   = '0;
      state_next = (state == SHOW) ? BLANK : SHOW;
    end else begin
      pre_next   = pre + PRE_W'(1);
    end
  end

  // Output decode: segment word passes only when SHOW and PWM slot is on.
  always_comb begin
    visible  = (state == SHOW) && pwm_on_p0;
    seg_next = visible ? seg_p0 : BLANK_PATTERN;
  end

  // PWM counter runs freely regardless of blink; gate is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt   <= '0;
      pwm_on_p0 <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      pwm_on_p0 <= pwm_gate(pwm_cnt, brightness);
    end
  end

  // Stage p0 captures seg_in; output stage drives the pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_p0  <= BLANK_PATTERN;
      seg_out <= BLANK_PATTERN;
    end else begin
      seg_p0  <= seg_in;
      seg_out <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: directed bench for seg_display_ctrl with a short blink
// period (CLK_HZ=40, BLINK_HZ=2 -> 10 cycles per half) and 4-bit brightness.
module tb_seg_display_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] seg_in;
  logic        blink_en;
  logic [3:0]  brightness;
  logic [15:0] seg_out;
  logic        blink_phase;

  int n_tests;
  int n_fail;

  seg_display_ctrl #(
    .CLK_HZ(40),
    .BLINK_HZ(2),
    .PWM_BITS(4),
    .SEG_W(16),
    .BLANK_PATTERN(16'hFFFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seg_in(seg_in),
    .blink_en(blink_en),
    .brightness(brightness),
    .seg_out(seg_out),
    .blink_phase(blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt_on;
    int cnt_off;
    logic [15:0] e_seg;
    logic        e_ph;

    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b1;
    seg_in     = 16'h0040;
    blink_en   = 1'b0;
    brightness = 4'hF;

    // Reset and latency
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_seg", 32'(seg_out), 32'h0000FFFF);
      check("rst_phase", 32'(blink_phase), 32'h0);
    end
    reset = 1'b0;
    tick();
    check("post_rst_c1", 32'(seg_out), 32'h0000FFFF);
    tick();
    check("post_rst_c2", 32'(seg_out), 32'h00000040);
    seg_in = 16'h0079;
    tick();
    check("lat_c1", 32'(seg_out), 32'h00000040);
    tick();
    check("lat_c2", 32'(seg_out), 32'h00000079);

    // Blink timing: 10 cycles pattern, 10 cycles dark; phase leads output by one
    seg_in = 16'h0024;
    for (int i = 0; i < 3; i++) tick();
    check("pre_blink", 32'(seg_out), 32'h00000024);
    blink_en = 1'b1;
    for (int i = 0; i < 52; i++) begin
      tick();
      e_seg = (((i / 10) % 2) == 0) ? 16'h0024 : 16'hFFFF;
      e_ph  = ((((i + 1) / 10) % 2) == 1);
      check($sformatf("blink_seg_%0d", i), 32'(seg_out), 32'(e_seg));
      check($sformatf("blink_ph_%0d", i), 32'(blink_phase), 32'(e_ph));
    end

    // Blink abort three cycles into BLANK
    blink_en = 1'b0;
    tick();
    check("abort_c1_seg", 32'(seg_out), 32'h0000FFFF);
    check("abort_c1_ph", 32'(blink_phase), 32'h0);
    tick();
    check("abort_c2_seg", 32'(seg_out), 32'h00000024);
    tick();
    check("abort_c3_seg", 32'(seg_out), 32'h00000024);
    check("abort_c3_ph", 32'(blink_phase), 32'h0);

    // Re-enable: full SHOW first; new word written during BLANK appears on SHOW
    blink_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      e_seg = (i < 10) ? 16'h0024 : ((i < 20) ? 16'hFFFF : 16'h0012);
      e_ph  = ((((i + 1) / 10) % 2) == 1);
      check($sformatf("reblink_seg_%0d", i), 32'(seg_out), 32'(e_seg));
      check($sformatf("reblink_ph_%0d", i), 32'(blink_phase), 32'(e_ph));
      if (i == 11) seg_in = 16'h0012;
    end

    // PWM duty with blink disabled
    blink_en   = 1'b0;
    seg_in     = 16'h0000;
    brightness = 4'd4;
    for (int i = 0; i < 4; i++) tick();
    for (int w = 0; w < 2; w++) begin
      cnt_on  = 0;
      cnt_off = 0;
      for (int i = 0; i < 16; i++) begin
        tick();
        if (seg_out == 16'h0000) cnt_on++;
        else if (seg_out == 16'hFFFF) cnt_off++;
      end
      check($sformatf("pwm4_on_w%0d", w), 32'(cnt_on), 32'd4);
      check($sformatf("pwm4_off_w%0d", w), 32'(cnt_off), 32'd12);
    end

    brightness = 4'd0;
    for (int i = 0; i < 3; i++) tick();
    cnt_off = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (seg_out == 16'hFFFF) cnt_off++;
    end
    check("pwm0_dark", 32'(cnt_off), 32'd16);

    brightness = 4'hF;
    for (int i = 0; i < 3; i++) tick();
    cnt_on = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (seg_out == 16'h0000) cnt_on++;
    end
    check("pwm15_full", 32'(cnt_on), 32'd16);

    // Reset mid-BLANK with brightness 7
    seg_in     = 16'h0055;
    brightness = 4'd7;
    blink_en   = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("pre_rst_in_blank", 32'(blink_phase), 32'h1);
    reset = 1'b1;
    tick();
    check("mid_rst_seg", 32'(seg_out), 32'h0000FFFF);
    check("mid_rst_ph", 32'(blink_phase), 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      tick();
      e_seg = ((k >= 2) && (((k - 2) % 16) < 7) && ((((k - 1) / 10) % 2) == 0))
              ? 16'h0055 : 16'hFFFF;
      e_ph  = (((k / 10) % 2) == 1);
      check($sformatf("after_rst_seg_%0d", k), 32'(seg_out), 32'(e_seg));
      check($sformatf("after_rst_ph_%0d", k), 32'(blink_phase), 32'(e_ph));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
